// File: rtl/isp_frame_ctrl.sv
// ---------------------------------------------------------------------------
// isp_frame_ctrl
//   Frame-synchronous configuration controller for the ISP pipeline.
//   A CPU-side bank of shadow registers holds per-stage enables and tuning
//   parameters. The shadow bank is copied to the active outputs only at frame
//   start (deferred commit) or, outside a frame, on an immediate commit, so no
//   stage sees its settings change mid-frame. The raw vsync/href timing is
//   monitored for line count and frame duration. Firmware gets a frame_done
//   pulse and sticky error flags.
//
// Ports
//   pclk, rst_n        pixel clock, synchronous active-low reset
//   in_href, in_vsync  raw input line / frame valid
//   reg_wen, reg_ren   register write / read strobes
//   reg_addr           register address (0..7)
//   reg_wdata          write data
//   reg_rdata          read data, valid one cycle after reg_ren
//   cfg_en             active stage enables, dpc = bit0
//   dpc_threshold, blc_*, nr_level, dgain_*, wb_*  active tuning values
//   frame_done         one-cycle pulse after an in_vsync falling edge
//   commit_pending     a deferred commit is armed
// ---------------------------------------------------------------------------
module isp_frame_ctrl #(
    parameter int unsigned BITS    = 8,
    parameter int unsigned HEIGHT  = 960,
    parameter logic [23:0] TIMEOUT = 24'd4000000
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic            reg_wen,
    input  logic            reg_ren,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic [12:0]     cfg_en,
    output logic [BITS-1:0] dpc_threshold,
    output logic [BITS-1:0] blc_r,
    output logic [BITS-1:0] blc_gr,
    output logic [BITS-1:0] blc_gb,
    output logic [BITS-1:0] blc_b,
    output logic [3:0]      nr_level,
    output logic [7:0]      dgain_gain,
    output logic [BITS-1:0] dgain_offset,
    output logic [7:0]      wb_rgain,
    output logic [7:0]      wb_ggain,
    output logic [7:0]      wb_bgain,
    output logic            frame_done,
    output logic            commit_pending
);

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_ACTIVE} state_e;

    typedef struct packed {
        logic [12:0]     ctrl;
        logic [BITS-1:0] dpc;
        logic [BITS-1:0] blc_r;
        logic [BITS-1:0] blc_gr;
        logic [BITS-1:0] blc_gb;
        logic [BITS-1:0] blc_b;
        logic [3:0]      nr;
        logic [7:0]      dg_gain;
        logic [BITS-1:0] dg_off;
        logic [7:0]      wb_r;
        logic [7:0]      wb_g;
        logic [7:0]      wb_b;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        ctrl: '0, dpc: '0, blc_r: '0, blc_gr: '0, blc_gb: '0, blc_b: '0,
        nr: '0, dg_gain: 8'h10, dg_off: '0,
        wb_r: 8'h10, wb_g: 8'h10, wb_b: 8'h10
    };

    state_e      state_q, state_d;
    cfg_t        shadow_q, shadow_d;
    cfg_t        active_q, active_d;
    logic        vs_q, href_q;
    logic        pending_q, pending_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [23:0] wd_cnt_q, wd_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_lines_q, err_lines_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_cmd_q, err_cmd_d;
    logic        frame_done_q, frame_done_d;
    logic [31:0] rdata_q, rdata_d;

    logic        fs, fe;
    logic        cmd_arm, cmd_imm, commit;
    logic        set_lines, set_timeout, set_cmd;
    logic        status_wr;
    logic [31:0] rd_val;

    // Only the low bits of some fields are used, depending on BITS.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;

    always_comb begin
        fs        = in_vsync & ~vs_q;
        fe        = ~in_vsync & vs_q;
        cmd_arm   = reg_wen && (reg_addr == 3'd6) && reg_wdata[0];
        cmd_imm   = reg_wen && (reg_addr == 3'd6) && reg_wdata[1];
        status_wr = reg_wen && (reg_addr == 3'd7);

        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        line_cnt_d   = line_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        commit       = 1'b0;
        set_lines    = 1'b0;
        set_timeout  = 1'b0;
        set_cmd      = 1'b0;

        // Shadow register writes
        if (reg_wen) begin
            case (reg_addr)
                3'd0: shadow_d.ctrl = reg_wdata[12:0];
                3'd1: shadow_d.dpc  = reg_wdata[BITS-1:0];
                3'd2: begin
                    shadow_d.blc_r  = reg_wdata[0  +: BITS];
                    shadow_d.blc_gr = reg_wdata[8  +: BITS];
                    shadow_d.blc_gb = reg_wdata[16 +: BITS];
                    shadow_d.blc_b  = reg_wdata[24 +: BITS];
                end
                3'd3: shadow_d.nr = reg_wdata[3:0];
                3'd4: begin
                    shadow_d.dg_gain = reg_wdata[7:0];
                    shadow_d.dg_off  = reg_wdata[8 +: BITS];
                end
                3'd5: begin
                    shadow_d.wb_r = reg_wdata[7:0];
                    shadow_d.wb_g = reg_wdata[15:8];
                    shadow_d.wb_b = reg_wdata[23:16];
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_SYNC: begin
                // fs is never honoured here: a partial frame at reset release is skipped
                commit    = cmd_imm;
                pending_d = cmd_imm ? 1'b0 : (pending_q | cmd_arm);
                if (!in_vsync) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                commit = cmd_imm | (fs & pending_q);
                // An arm landing on fs survives into the next frame
                if (cmd_imm)  pending_d = 1'b0;
                else if (fs)  pending_d = cmd_arm;
                else          pending_d = pending_q | cmd_arm;
                if (fs) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                pending_d = pending_q | cmd_arm;
                set_cmd   = cmd_imm;
                if (wd_cnt_q >= TIMEOUT) set_timeout = 1'b1;
                if (fe) begin
                    set_lines    = (line_cnt_q != 12'(HEIGHT));
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    frame_done_d = 1'b1;
                    line_cnt_d   = '0;
                    wd_cnt_d     = '0;
                    state_d      = ST_IDLE;
                end else begin
                    if (in_href && !href_q && (line_cnt_q != '1))
                        line_cnt_d = line_cnt_q + 12'd1;
                    if (wd_cnt_q != '1)
                        wd_cnt_d = wd_cnt_q + 24'd1;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // Active takes the pre-write shadow value when a write coincides
        if (commit) active_d = shadow_q;

        // Sticky errors; a W1C clear loses to a simultaneous set
        err_lines_d   = (err_lines_q   & ~(status_wr & reg_wdata[4])) | set_lines;
        err_timeout_d = (err_timeout_q & ~(status_wr & reg_wdata[5])) | set_timeout;
        err_cmd_d     = (err_cmd_q     & ~(status_wr & reg_wdata[6])) | set_cmd;

        // Read mux returns shadow (pre-write) values
        rd_val = '0;
        case (reg_addr)
            3'd0: rd_val[12:0] = shadow_q.ctrl;
            3'd1: rd_val[BITS-1:0] = shadow_q.dpc;
            3'd2: begin
                rd_val[0  +: BITS] = shadow_q.blc_r;
                rd_val[8  +: BITS] = shadow_q.blc_gr;
                rd_val[16 +: BITS] = shadow_q.blc_gb;
                rd_val[24 +: BITS] = shadow_q.blc_b;
            end
            3'd3: rd_val[3:0] = shadow_q.nr;
            3'd4: begin
                rd_val[7:0]       = shadow_q.dg_gain;
                rd_val[8 +: BITS] = shadow_q.dg_off;
            end
            3'd5: rd_val[23:0] = {shadow_q.wb_b, shadow_q.wb_g, shadow_q.wb_r};
            3'd7: rd_val = {frame_cnt_q, 9'b0, err_cmd_q, err_timeout_q,
                            err_lines_q, 2'b0, (state_q == ST_ACTIVE), pending_q};
            default: rd_val = '0;
        endcase
        rdata_d = reg_ren ? rd_val : rdata_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q       <= ST_SYNC;
            vs_q          <= 1'b1;
            href_q        <= 1'b0;
            shadow_q      <= CFG_RST;
            active_q      <= CFG_RST;
            pending_q     <= 1'b0;
            line_cnt_q    <= '0;
            wd_cnt_q      <= '0;
            frame_cnt_q   <= '0;
            err_lines_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cmd_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= in_vsync;
            href_q        <= in_href;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            line_cnt_q    <= line_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            err_lines_q   <= err_lines_d;
            err_timeout_q <= err_timeout_d;
            err_cmd_q     <= err_cmd_d;
            frame_done_q  <= frame_done_d;
            rdata_q       <= rdata_d;
        end
    end

    assign reg_rdata      = rdata_q;
    assign cfg_en         = active_q.ctrl;
    assign dpc_threshold  = active_q.dpc;
    assign blc_r          = active_q.blc_r;
    assign blc_gr         = active_q.blc_gr;
    assign blc_gb         = active_q.blc_gb;
    assign blc_b          = active_q.blc_b;
    assign nr_level       = active_q.nr;
    assign dgain_gain     = active_q.dg_gain;
    assign dgain_offset   = active_q.dg_off;
    assign wb_rgain       = active_q.wb_r;
    assign wb_ggain       = active_q.wb_g;
    assign wb_bgain       = active_q.wb_b;
    assign frame_done     = frame_done_q;
    assign commit_pending = pending_q;

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_isp_frame_ctrl
//   Scoreboard bench for isp_frame_ctrl. Stimulus pushes expected values into
//   three queues (read responses, frame_done pulses, output probes); a monitor
//   on the falling edge pops and compares whenever the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_isp_frame_ctrl;

    localparam int unsigned BITS = 8;

    logic            pclk = 1'b0;
    logic            rst_n;
    logic            in_href, in_vsync;
    logic            reg_wen, reg_ren;
    logic [2:0]      reg_addr;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;
    logic [12:0]     cfg_en;
    logic [BITS-1:0] dpc_threshold, blc_r, blc_gr, blc_gb, blc_b, dgain_offset;
    logic [3:0]      nr_level;
    logic [7:0]      dgain_gain, wb_rgain, wb_ggain, wb_bgain;
    logic            frame_done, commit_pending;

    isp_frame_ctrl #(
        .BITS    (BITS),
        .HEIGHT  (4),
        .TIMEOUT (24'd60)
    ) dut (
        .pclk           (pclk),
        .rst_n          (rst_n),
        .in_href        (in_href),
        .in_vsync       (in_vsync),
        .reg_wen        (reg_wen),
        .reg_ren        (reg_ren),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_rdata      (reg_rdata),
        .cfg_en         (cfg_en),
        .dpc_threshold  (dpc_threshold),
        .blc_r          (blc_r),
        .blc_gr         (blc_gr),
        .blc_gb         (blc_gb),
        .blc_b          (blc_b),
        .nr_level       (nr_level),
        .dgain_gain     (dgain_gain),
        .dgain_offset   (dgain_offset),
        .wb_rgain       (wb_rgain),
        .wb_ggain       (wb_ggain),
        .wb_bgain       (wb_bgain),
        .frame_done     (frame_done),
        .commit_pending (commit_pending)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t rd_q[$];
    item_t fd_q[$];
    item_t pr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int probe_sel = 0;
    logic ren_seen = 1'b0;

    localparam int P_CFG = 1, P_WB = 2, P_PEND = 3, P_DG = 4, P_BLC = 5, P_DPC = 6, P_NR = 7;

    function automatic logic [31:0] probe_val(int s);
        case (s)
            P_CFG:  return {19'b0, cfg_en};
            P_WB:   return {8'b0, wb_bgain, wb_ggain, wb_rgain};
            P_PEND: return {31'b0, commit_pending};
            P_DG:   return {16'b0, dgain_offset, dgain_gain};
            P_BLC:  return {blc_b, blc_gb, blc_gr, blc_r};
            P_DPC:  return {24'b0, dpc_threshold};
            P_NR:   return {28'b0, nr_level};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    always @(posedge pclk) ren_seen <= reg_ren && rst_n;

    // Monitor: compares whatever the DUT presents this cycle
    always @(negedge pclk) begin
        item_t it;
        if (ren_seen) begin
            if (rd_q.size() == 0) check("rd_unexpected", reg_rdata, 32'hxxxx_xxxx);
            else begin it = rd_q.pop_front(); check(it.name, reg_rdata, it.exp); end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) check("frame_done_unexpected", 32'd1, 32'd0);
            else begin it = fd_q.pop_front(); check(it.name, {19'b0, cfg_en}, it.exp); end
        end
        if (probe_sel != 0) begin
            if (pr_q.size() == 0) check("probe_unexpected", 32'd1, 32'd0);
            else begin it = pr_q.pop_front(); check(it.name, probe_val(it.sel), it.exp); end
        end
    end

    task automatic cyc(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            reg_wen   = 1'b0;
            reg_ren   = 1'b0;
            probe_sel = 0;
        end
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
        cyc();
    endtask

    task automatic rd(logic [2:0] a, logic [31:0] e, string name);
        item_t it;
        it.name = name; it.sel = 0; it.exp = e;
        rd_q.push_back(it);
        reg_ren = 1'b1; reg_addr = a;
        cyc();
    endtask

    task automatic probe(int s, logic [31:0] e, string name);
        item_t it;
        it.name = name; it.sel = s; it.exp = e;
        pr_q.push_back(it);
        probe_sel = s;
        cyc();
    endtask

    task automatic expect_fd(logic [31:0] e, string name);
        item_t it;
        it.name = name; it.sel = 0; it.exp = e;
        fd_q.push_back(it);
    endtask

    task automatic lines(int n);
        for (int i = 0; i < n; i++) begin
            in_href = 1'b1; cyc(3);
            in_href = 1'b0; cyc(2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_href = 1'b0; in_vsync = 1'b0;
        reg_wen = 1'b0; reg_ren = 1'b0; reg_addr = '0; reg_wdata = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Reset values
        rd(3'd0, 32'h0, "rst_ctrl");
        rd(3'd1, 32'h0, "rst_dpc");
        rd(3'd2, 32'h0, "rst_blc");
        rd(3'd3, 32'h0, "rst_nr");
        rd(3'd4, 32'h0000_0010, "rst_dgain");
        rd(3'd5, 32'h0010_1010, "rst_wb");
        rd(3'd6, 32'h0, "rst_commit");
        rd(3'd7, 32'h0, "rst_status");
        probe(P_CFG, 32'h0, "rst_cfg_en");
        probe(P_WB, 32'h0010_1010, "rst_wb_out");
        probe(P_DG, 32'h0000_0010, "rst_dg_out");

        // Deferred commit applied at frame start
        wr(3'd0, 32'h1FFF);
        wr(3'd1, 32'h25);
        wr(3'd2, 32'h0403_0201);
        wr(3'd3, 32'h5);
        wr(3'd4, 32'h0320);
        wr(3'd6, 32'h1);
        rd(3'd7, 32'h1, "armed_status");
        probe(P_CFG, 32'h0, "cfg_before_frame");
        in_vsync = 1'b1;
        probe(P_CFG, 32'h0, "cfg_at_fs_cycle");
        probe(P_CFG, 32'h1FFF, "cfg_after_fs");
        probe(P_PEND, 32'h0, "pending_cleared");
        probe(P_DPC, 32'h25, "dpc_after_fs");
        probe(P_BLC, 32'h0403_0201, "blc_after_fs");
        probe(P_DG, 32'h0320, "dg_after_fs");
        probe(P_NR, 32'h5, "nr_after_fs");
        lines(4);
        expect_fd(32'h1FFF, "fd_frame1");
        in_vsync = 1'b0; cyc(3);
        rd(3'd7, 32'h0001_0000, "status_frame1");

        // Immediate commit mid-frame is rejected
        in_vsync = 1'b1; cyc(2);
        lines(1);
        wr(3'd5, 32'h0020_2020);
        wr(3'd6, 32'h2);
        probe(P_WB, 32'h0010_1010, "wb_unchanged_midframe");
        rd(3'd5, 32'h0020_2020, "wb_shadow");
        rd(3'd7, 32'h0001_0042, "status_err_cmd");
        wr(3'd7, 32'h40);
        rd(3'd7, 32'h0001_0002, "status_cmd_cleared");
        lines(3);
        expect_fd(32'h1FFF, "fd_frame2");
        in_vsync = 1'b0; cyc(3);
        rd(3'd7, 32'h0002_0000, "status_frame2");
        probe(P_WB, 32'h0010_1010, "wb_still_old");

        // Short frame and timeout
        in_vsync = 1'b1; cyc(2);
        lines(3);
        expect_fd(32'h1FFF, "fd_short");
        in_vsync = 1'b0; cyc(3);
        rd(3'd7, 32'h0003_0010, "status_err_lines");
        wr(3'd7, 32'h10);
        rd(3'd7, 32'h0003_0000, "status_lines_cleared");
        in_vsync = 1'b1; cyc(70);
        rd(3'd7, 32'h0003_0022, "status_timeout");
        wr(3'd7, 32'h20);
        rd(3'd7, 32'h0003_0022, "timeout_set_wins");
        expect_fd(32'h1FFF, "fd_timeout");
        in_vsync = 1'b0; cyc(3);
        rd(3'd7, 32'h0004_0030, "status_both_errs");
        wr(3'd7, 32'h70);
        rd(3'd7, 32'h0004_0000, "status_all_cleared");

        // Arm coincident with fs is deferred to the following frame
        wr(3'd0, 32'h0AAA);
        in_vsync = 1'b1;
        wr(3'd6, 32'h1);
        probe(P_CFG, 32'h1FFF, "cfg_no_update_coincident");
        probe(P_PEND, 32'h1, "pending_kept");
        lines(4);
        expect_fd(32'h1FFF, "fd_frame5");
        in_vsync = 1'b0; cyc(3);
        in_vsync = 1'b1; cyc();
        probe(P_CFG, 32'h0AAA, "cfg_next_frame");
        probe(P_PEND, 32'h0, "pending_consumed");
        lines(4);
        expect_fd(32'h0AAA, "fd_frame6");
        in_vsync = 1'b0; cyc(3);

        // Immediate commit in IDLE, with arm bit, clears pending
        wr(3'd0, 32'h0155);
        wr(3'd6, 32'h1);
        probe(P_PEND, 32'h1, "pending_armed_idle");
        wr(3'd6, 32'h3);
        probe(P_CFG, 32'h0155, "cfg_immediate");
        probe(P_PEND, 32'h0, "pending_cleared_imm");
        // Read and write together: read returns pre-write value
        reg_wen = 1'b1; reg_addr = 3'd0; reg_wdata = 32'h0777;
        rd(3'd0, 32'h0155, "rw_same_cycle");
        rd(3'd0, 32'h0777, "rw_after");
        rd(3'd7, 32'h0006_0000, "status_frame6");

        // Reset mid-frame: remainder ignored, next frame counts
        in_vsync = 1'b1; cyc(2);
        lines(2);
        rst_n = 1'b0; cyc(2);
        rst_n = 1'b1; cyc();
        probe(P_CFG, 32'h0, "cfg_after_midreset");
        probe(P_WB, 32'h0010_1010, "wb_after_midreset");
        rd(3'd7, 32'h0, "status_in_sync");
        lines(2);
        in_vsync = 1'b0; cyc(3);
        rd(3'd7, 32'h0, "status_partial_ignored");
        in_vsync = 1'b1; cyc(2);
        lines(4);
        expect_fd(32'h0, "fd_after_reset");
        in_vsync = 1'b0; cyc(3);
        rd(3'd7, 32'h0001_0000, "status_after_reset_frame");

        cyc(3);
        check("rd_queue_drained", rd_q.size(), 32'd0);
        check("fd_queue_drained", fd_q.size(), 32'd0);
        check("probe_queue_drained", pr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/isp_frame_ctrl.md
Name: isp_frame_ctrl

Overview:
- Frame-synchronous configuration controller for the ISP pipeline.
- Owns a CPU-side register bank of shadow registers for per-stage enables and key tuning parameters.
- Copies shadow registers to the active outputs only at frame start, so no stage changes settings mid-frame.
- Monitors the raw input timing (vsync/href): counts frames and lines, flags malformed frames, and pulses frame_done to firmware.

Parameters:
- BITS, 8, pixel bit depth; legal range 1..8 (BLC packs 4 fields in 32 bits).
- HEIGHT, 960, expected href lines per frame.
- TIMEOUT, 24'd4000000, max pclk cycles a frame may last before err_timeout sets.

Ports:
- pclk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_href  in  1  raw input line valid (same signal fed to the pipeline input).
- in_vsync  in  1  raw input frame valid; high for the whole frame.
- reg_wen  in  1  register write strobe, one cycle per write.
- reg_ren  in  1  register read strobe.
- reg_addr  in  3  register address.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid 1 cycle after reg_ren.
- cfg_en  out  13  active enables {stat_awb,stat_ae,ee,nr2d,gamma,csc,ccm,wb,demosic,dgain,bnr,blc,dpc}, where dpc = bit0.
- dpc_threshold  out  BITS  active DPC threshold.
- blc_r, blc_gr, blc_gb, blc_b  out  BITS each  active black levels.
- nr_level  out  4  active BNR level.
- dgain_gain  out  8  active digital gain.
- dgain_offset  out  BITS  active digital gain offset.
- wb_rgain, wb_ggain, wb_bgain  out  8 each  active white-balance gains.
- frame_done  out  1  one-cycle pulse at in_vsync falling edge.
- commit_pending  out  1  a deferred commit is armed.

Behaviour:
Register map (shadow registers are RW; reads return shadow, not active):
- 0: CTRL[12:0] enables; reset 0.
- 1: DPC_TH[BITS-1:0]; reset 0.
- 2: BLC = {b,gb,gr,r}, each packed at an 8-bit stride; reset 0.
- 3: NR[3:0]; reset 0.
- 4: DGAIN = {offset[15:8], gain[7:0]}; reset gain 8'h10, offset 0.
- 5: WB = {b[23:16], g[15:8], r[7:0]}; reset 8'h10 each.
- 6: COMMIT (write-only, reads 0). Bit0 = arm deferred commit. Bit1 = immediate commit.
- 7: STATUS (read fields):
  - bit0 = commit_pending
  - bit1 = in_frame
  - bit4 = err_lines
  - bit5 = err_timeout
  - bit6 = err_cmd
  - [31:16] = frame_cnt
  Writing 1 to bits 4..6 clears those bits (W1C); other bits ignore writes.
- Unused upper bits read 0. reg_wen and reg_ren in the same cycle: the read returns the pre-write value.

Reset: every output equals its shadow reset value; reg_rdata=0, frame_done=0, all counters and status bits 0. A reset mid-frame discards that frame.

Edge detection:
- vs_d is the prior-cycle in_vsync; it resets to 1.
- Frame start (fs) = in_vsync & ~vs_d. Frame end (fe) = ~in_vsync & vs_d.

State machine:
- SYNC (reset state): waits for in_vsync=0, then IDLE. No fs is honoured in SYNC, so a partial frame at reset release is ignored.
- IDLE: on fs, go to ACTIVE. If commit_pending, active <= shadow on this clock edge; outputs change the cycle after fs is sampled. Clear commit_pending.
- ACTIVE (in_frame=1):
  - Count href rising edges into line_cnt (12-bit, saturating).
  - Count cycles into wd_cnt (24-bit, saturating). Reaching TIMEOUT sets err_timeout.
  - On fe: if line_cnt != HEIGHT, set err_lines. frame_cnt += 1 (wraps at 16 bits). frame_done pulses in the cycle after fe is sampled. Clear line_cnt and wd_cnt. Go to IDLE.
- A fs seen while in ACTIVE is impossible by construction: fs requires vsync low the prior cycle, which forces fe and ACTIVE->IDLE first.

Commit rules:
- Bit0 write sets commit_pending.
- If that write lands in the same cycle as fs, the current commit uses shadow values as of that cycle. commit_pending stays set, so the request applies at the next frame.
- A shadow write coinciding with a commit: active receives the old shadow value; shadow takes the new value.
- Bit1 (immediate) in SYNC/IDLE: active <= shadow next cycle, and commit_pending clears.
- Bit1 in ACTIVE: ignored, and err_cmd sets.
- Bits 0 and 1 written together in IDLE: the immediate commit applies and pending stays cleared.
- Errors are sticky until cleared by W1C. A W1C clear coinciding with a set: the set wins.

Test Plan:
- Reset then read all regs -> CTRL=0, DGAIN=0x0010, WB=0x101010, outputs match, STATUS=0.
- In IDLE, write CTRL=0x1FFF, COMMIT=1; drive a 960-line frame -> cfg_en stays 0 until the cycle after fs, then 0x1FFF. commit_pending clears. frame_done pulses once at frame end. frame_cnt=1. err_lines=0.
- Mid-frame write WB=0x202020 and COMMIT=2 -> outputs unchanged, err_cmd=1. Write STATUS=0x40 -> err_cmd=0.
- Frame with 959 lines -> err_lines=1 after fe. Hold vsync high for TIMEOUT cycles -> err_timeout=1.
- COMMIT=1 write coincident with fs -> no update this frame, commit_pending=1, update at the following fs.
- Assert rst_n=0 mid-frame while vsync stays high -> outputs revert to reset values, state SYNC. The remainder of that frame is ignored (frame_cnt stays 0); the next full frame counts.
